// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: pc_op encodings,
// FSM state type, compare-result constants and a saturating counter helper.
package pc_seq_pkg;

  // Branch resolution opcodes from the execute stage
  localparam logic [1:0] PC_OP_NONE = 2'b00;
  localparam logic [1:0] PC_OP_JMP  = 2'b01;
  localparam logic [1:0] PC_OP_JZ   = 2'b10;
  localparam logic [1:0] PC_OP_JNZ  = 2'b11;

  // Compare results the ALU produces for a true / false condition
  localparam logic [7:0] CMP_TRUE  = 8'd1;
  localparam logic [7:0] CMP_FALSE = 8'd0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    ISSUE   = 2'd2,
    RESOLVE = 2'd3
  } pc_seq_state_e;

  // 16-bit increment that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pc_sequencer_branch_decide.sv
// branch_decide: purely combinational jump decision from pc_op and the
// ALU compare result. jz/jnz only treat the exact values 1 and 0 as
// true/false; any other compare value leaves the branch not taken.
module branch_decide
  import pc_seq_pkg::*;
(
  input  logic [1:0] pc_op,
  input  logic [7:0] cmp_res,
  output logic       taken
);

  // Decode the opcode and qualify conditional jumps by the compare result
  always_comb begin
    taken = 1'b0;
    unique case (pc_op)
      PC_OP_NONE: taken = 1'b0;
      PC_OP_JMP:  taken = 1'b1;
      PC_OP_JZ:   taken = (cmp_res == CMP_TRUE);
      PC_OP_JNZ:  taken = (cmp_res == CMP_FALSE);
      default:    taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multicycle fetch / issue / resolve program-counter sequencer.
// Optional statistics counters (instr_cnt, taken_cnt) are built only when
// the macro PC_SEQ_STATS_EN is defined.
//
// Handshakes: every channel transfers only on a clock edge where both its
// valid and ready are high (imem_req/imem_ack, instr_valid/instr_ready,
// br_valid/br_ready). Valid sides hold their payload until the transfer;
// an ack or valid presented while the FSM is in another state is ignored.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run_en,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_out,
  input  logic               br_valid,
  output logic               br_ready,
  input  logic [1:0]         pc_op,
  input  logic [7:0]         cmp_res,
  input  logic [ADDR_W-1:0]  jmp_target,
  output logic [ADDR_W-1:0]  pc,
  output logic               taken,
`ifdef PC_SEQ_STATS_EN
  output logic [15:0]        instr_cnt,
  output logic [15:0]        taken_cnt,
`endif
  output pc_seq_state_e      state_dbg
);

  pc_seq_state_e      state_q, state_d;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] instr_q;
  logic               taken_q;
  logic               br_taken;
  logic               fetch_done;
  logic               issue_done;
  logic               br_fire;

  branch_decide u_branch_decide (
    .pc_op   (pc_op),
    .cmp_res (cmp_res),
    .taken   (br_taken)
  );

  // Channel transfer qualifiers, each gated by the state that owns it
  assign fetch_done = (state_q == FETCH)   && imem_ack;
  assign issue_done = (state_q == ISSUE)   && instr_ready;
  assign br_fire    = (state_q == RESOLVE) && br_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one state per pipeline phase of an instruction
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (run_en)     state_d = FETCH;
      FETCH:   if (fetch_done) state_d = ISSUE;
      ISSUE:   if (issue_done) state_d = RESOLVE;
      RESOLVE: if (br_fire)    state_d = run_en ? FETCH : IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // Datapath: capture fetched word, advance or redirect pc, flag taken jumps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      taken_q <= 1'b0;
    end else begin
      taken_q <= br_fire && br_taken;
      if (fetch_done) begin
        instr_q <= imem_data;
      end
      if (br_fire) begin
        pc_q <= br_taken ? jmp_target : pc_q + ADDR_W'(1);
      end
    end
  end

`ifdef PC_SEQ_STATS_EN
  logic [15:0] instr_cnt_q;
  logic [15:0] taken_cnt_q;

  // Saturating counts of resolved instructions and taken jumps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt_q <= 16'd0;
      taken_cnt_q <= 16'd0;
    end else begin
      if (br_fire) begin
        instr_cnt_q <= sat_inc16(instr_cnt_q);
      end
      if (br_fire && br_taken) begin
        taken_cnt_q <= sat_inc16(taken_cnt_q);
      end
    end
  end

  assign instr_cnt = instr_cnt_q;
  assign taken_cnt = taken_cnt_q;
`endif

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == ISSUE);
  assign instr_out   = instr_q;
  assign br_ready    = (state_q == RESOLVE);
  assign pc          = pc_q;
  assign taken       = taken_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer and its branch_decide sub-module.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               run_en      = 1'b0;
  logic               imem_ack    = 1'b0;
  logic [INSTR_W-1:0] imem_data   = '0;
  logic               instr_ready = 1'b0;
  logic               br_valid    = 1'b0;
  logic [1:0]         pc_op       = '0;
  logic [7:0]         cmp_res     = '0;
  logic [ADDR_W-1:0]  jmp_target  = '0;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr_out;
  logic               br_ready;
  logic [ADDR_W-1:0]  pc;
  logic               taken;
  pc_seq_state_e      state_dbg;
`ifdef PC_SEQ_STATS_EN
  logic [15:0]        instr_cnt;
  logic [15:0]        taken_cnt;
`endif

  pc_sequencer #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .RESET_PC(8'h00)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run_en      (run_en),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .br_valid    (br_valid),
    .br_ready    (br_ready),
    .pc_op       (pc_op),
    .cmp_res     (cmp_res),
    .jmp_target  (jmp_target),
    .pc          (pc),
    .taken       (taken),
`ifdef PC_SEQ_STATS_EN
    .instr_cnt   (instr_cnt),
    .taken_cnt   (taken_cnt),
`endif
    .state_dbg   (state_dbg)
  );

  // Standalone branch_decide for its own table
  logic [1:0] bd_op  = '0;
  logic [7:0] bd_cmp = '0;
  logic       bd_taken;

  branch_decide u_bd (
    .pc_op   (bd_op),
    .cmp_res (bd_cmp),
    .taken   (bd_taken)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [ADDR_W-1:0] exp_q[$];   // expected next fetch addresses
  int model_res = 0;             // expected instr_cnt
  int model_tk  = 0;             // expected taken_cnt

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction memory contents: derived from the address
  function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a ^ 8'h5A, a};
  endfunction

  // Reference decision rule
  function automatic logic model_taken(input logic [1:0] op, input logic [7:0] cmp);
    if (op == 2'd1) return 1'b1;
    if (op == 2'd2) return cmp == 8'd1;
    if (op == 2'd3) return cmp == 8'd0;
    return 1'b0;
  endfunction

  // ---------------- driver: one full instruction ----------------
  task automatic run_instr(input logic [1:0] op, input logic [7:0] cmp, input logic [7:0] tgt,
                           input int ack_d, input int rdy_d, input int br_d, input bit early,
                           input bit has_exp, input logic exp_tk, input logic [7:0] exp_next);
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] word;
    logic               tk;
    logic [ADDR_W-1:0]  nxt;
    int                 waited;
    waited = 0;
    while (!imem_req && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!imem_req) begin
      check("fetch_timeout", imem_req, 1);
      return;
    end
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL exp_q_empty: fetch at %0h with nothing expected", imem_addr);
      return;
    end
    addr = exp_q.pop_front();
    check("imem_addr", imem_addr, addr);
    for (int i = 0; i < ack_d; i++) begin
      @(negedge clk);
      check("req_held", imem_req, 1);
      check("addr_held", imem_addr, addr);
      check("no_valid_in_fetch", instr_valid, 0);
    end
    word      = mem_word(addr);
    imem_data = word;
    imem_ack  = 1'b1;
    @(negedge clk);
    imem_ack  = 1'b0;
    imem_data = 16'($urandom);
    check("instr_valid", instr_valid, 1);
    check("instr_out", instr_out, word);
    check("req_drop", imem_req, 0);
    if (early) begin
      br_valid   = 1'b1;
      pc_op      = op;
      cmp_res    = cmp;
      jmp_target = tgt;
    end
    for (int i = 0; i < rdy_d; i++) begin
      @(negedge clk);
      check("valid_held", instr_valid, 1);
      check("instr_out_stable", instr_out, word);
      check("br_ready_low_in_issue", br_ready, 0);
      check("pc_hold_in_issue", pc, addr);
      check("no_taken_in_issue", taken, 0);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    check("br_ready", br_ready, 1);
    check("valid_drop", instr_valid, 0);
    check("pc_before_resolve", pc, addr);
    if (!early) begin
      for (int i = 0; i < br_d; i++) begin
        @(negedge clk);
        check("br_ready_held", br_ready, 1);
        check("pc_hold_in_resolve", pc, addr);
      end
      br_valid   = 1'b1;
      pc_op      = op;
      cmp_res    = cmp;
      jmp_target = tgt;
    end
    @(negedge clk);
    br_valid = 1'b0;
    pc_op    = 2'($urandom);
    cmp_res  = 8'($urandom);
    tk  = model_taken(op, cmp);
    nxt = tk ? tgt : addr + 8'd1;
    if (has_exp) begin
      tk  = exp_tk;
      nxt = exp_next;
    end
    if (model_res < 65535) model_res++;
    if (tk && model_tk < 65535) model_tk++;
    check("taken", taken, tk);
    check("pc_update", pc, nxt);
    check("refetch_req", imem_req, run_en);
    check("br_ready_drop", br_ready, 0);
`ifdef PC_SEQ_STATS_EN
    check("instr_cnt", instr_cnt, model_res);
    check("taken_cnt", taken_cnt, model_tk);
`endif
    @(negedge clk);
    check("taken_one_cycle", taken, 0);
    exp_q.push_back(nxt);
  endtask

  // ---------------- stimulus tables ----------------
  typedef struct {
    logic [1:0] op;
    logic [7:0] cmp;
    logic       exp;
  } bd_vec_t;

  typedef struct {
    logic [1:0] op;
    logic [7:0] cmp;
    logic [7:0] tgt;
    int         ack_d;
    int         rdy_d;
    logic       exp_tk;
    logic [7:0] exp_next;
  } seq_vec_t;

  bd_vec_t  bd_tab[11];
  seq_vec_t seq_tab[13];

  initial begin
    logic [7:0] c;
    logic [1:0] o;

    bd_tab[0]  = '{2'd0, 8'h00, 1'b0};
    bd_tab[1]  = '{2'd0, 8'h01, 1'b0};
    bd_tab[2]  = '{2'd1, 8'h00, 1'b1};
    bd_tab[3]  = '{2'd1, 8'h33, 1'b1};
    bd_tab[4]  = '{2'd2, 8'h01, 1'b1};
    bd_tab[5]  = '{2'd2, 8'h00, 1'b0};
    bd_tab[6]  = '{2'd2, 8'h02, 1'b0};
    bd_tab[7]  = '{2'd3, 8'h00, 1'b1};
    bd_tab[8]  = '{2'd3, 8'h01, 1'b0};
    bd_tab[9]  = '{2'd3, 8'h07, 1'b0};
    bd_tab[10] = '{2'd3, 8'hFF, 1'b0};

    // Walk from reset pc 0: sequential, jmp, jz/jnz both ways, wrap at FF
    seq_tab[0]  = '{2'd0, 8'h00, 8'h99, 0, 0, 1'b0, 8'h01};
    seq_tab[1]  = '{2'd0, 8'h01, 8'h99, 0, 0, 1'b0, 8'h02};
    seq_tab[2]  = '{2'd0, 8'h00, 8'h99, 0, 0, 1'b0, 8'h03};
    seq_tab[3]  = '{2'd0, 8'h00, 8'h99, 0, 0, 1'b0, 8'h04};
    seq_tab[4]  = '{2'd0, 8'h00, 8'h99, 1, 0, 1'b0, 8'h05};
    seq_tab[5]  = '{2'd1, 8'h00, 8'h40, 0, 0, 1'b1, 8'h40};
    seq_tab[6]  = '{2'd2, 8'h01, 8'h80, 0, 1, 1'b1, 8'h80};
    seq_tab[7]  = '{2'd2, 8'h00, 8'h10, 0, 0, 1'b0, 8'h81};
    seq_tab[8]  = '{2'd3, 8'h00, 8'hFE, 2, 0, 1'b1, 8'hFE};
    seq_tab[9]  = '{2'd3, 8'h01, 8'h20, 0, 0, 1'b0, 8'hFF};
    seq_tab[10] = '{2'd3, 8'h07, 8'h30, 3, 2, 1'b0, 8'h00};
    seq_tab[11] = '{2'd0, 8'h00, 8'h55, 0, 0, 1'b0, 8'h01};
    seq_tab[12] = '{2'd1, 8'h00, 8'hFF, 0, 0, 1'b1, 8'hFF};

    // --- branch_decide unit table ---
    for (int i = 0; i < 11; i++) begin
      bd_op  = bd_tab[i].op;
      bd_cmp = bd_tab[i].cmp;
      #1;
      check($sformatf("bd_vec%0d", i), bd_taken, bd_tab[i].exp);
    end

    // --- reset state ---
    repeat (3) @(negedge clk);
    check("rst_state", state_dbg, IDLE);
    check("rst_pc", pc, 8'h00);
    check("rst_imem_req", imem_req, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instr_out", instr_out, 0);
    check("rst_br_ready", br_ready, 0);
    check("rst_taken", taken, 0);
`ifdef PC_SEQ_STATS_EN
    check("rst_instr_cnt", instr_cnt, 0);
    check("rst_taken_cnt", taken_cnt, 0);
`endif

    // Release with run_en=1: fetch request after the first rising edge
    run_en = 1'b1;
    rst_n  = 1'b1;
    @(negedge clk);
    check("first_req_latency", imem_req, 1);
    exp_q.push_back(8'h00);

    // --- directed table walk ---
    for (int i = 0; i < 13; i++) begin
      run_instr(seq_tab[i].op, seq_tab[i].cmp, seq_tab[i].tgt, seq_tab[i].ack_d,
                seq_tab[i].rdy_d, 0, (i == 6), 1'b1, seq_tab[i].exp_tk, seq_tab[i].exp_next);
    end

    // --- run_en dropped during fetch: fetch completes, then idle ---
    run_en = 1'b0;
    run_instr(2'd0, 8'h00, 8'h00, 1, 1, 1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      check("idle_no_req", imem_req, 0);
      check("idle_state", state_dbg, IDLE);
      @(negedge clk);
    end
    run_en = 1'b1;
    @(negedge clk);
    check("restart_req", imem_req, 1);
    run_instr(2'd1, 8'h00, 8'h77, 0, 0, 0, 1'b0, 1'b0, 1'b0, 8'h00);

    // --- reset mid-fetch with a late ack ---
    begin
      int w;
      w = 0;
      while (!imem_req && w < 20) begin
        @(negedge clk);
        w++;
      end
      check("pre_reset_fetch", imem_req, 1);
      check("pre_reset_pc", pc, 8'h77);
    end
    rst_n = 1'b0;
    #1;
    check("async_rst_pc", pc, 8'h00);
    check("async_rst_req", imem_req, 0);
    check("async_rst_state", state_dbg, IDLE);
    @(negedge clk);
    rst_n     = 1'b1;
    imem_ack  = 1'b1;
    imem_data = 16'hDEAD;
    @(negedge clk);
    imem_ack = 1'b0;
    check("late_ack_ignored", instr_valid, 0);
    check("refetch_after_rst", imem_req, 1);
    check("refetch_addr", imem_addr, 8'h00);
    check("instr_out_after_rst", instr_out, 0);
    exp_q.delete();
    exp_q.push_back(8'h00);
    model_res = 0;
    model_tk  = 0;

    // --- randomized instructions against the reference model ---
    for (int n = 0; n < 40; n++) begin
      o = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0:       c = 8'h00;
        1:       c = 8'h01;
        default: c = 8'($urandom_range(2, 255));
      endcase
      run_instr(o, c, 8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 2), bit'($urandom_range(0, 1)), 1'b0, 1'b0, 8'h00);
    end

`ifdef PC_SEQ_STATS_EN
    // --- counter saturation ---
    force dut.instr_cnt_q = 16'hFFFE;
    force dut.taken_cnt_q = 16'hFFFF;
    #1;
    release dut.instr_cnt_q;
    release dut.taken_cnt_q;
    model_res = 65534;
    model_tk  = 65535;
    run_instr(2'd1, 8'h00, 8'h12, 0, 0, 0, 1'b0, 1'b0, 1'b0, 8'h00);
    run_instr(2'd1, 8'h00, 8'h34, 0, 0, 0, 1'b0, 1'b0, 1'b0, 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
